// File: rtl/multicycle_control_fsm.sv
// Moore controller sequencing a shared multicycle RISC-V datapath: one datapath action per cycle,
// 3-5 cycles per instruction, stalling in FETCH/MEMREAD/MEMWRITE until MemReady.
module multicycle_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [2:0] ALUControl,
   output logic       IllegalOp,
   output logic [3:0] State
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } aluop_t;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   aluop_t alu_op;
   logic   pc_we, ir_we, mem_we, reg_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      mem_we    = 1'b0;
      reg_we    = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      alu_op    = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_we     = MemReady;
            pc_we     = MemReady;
            state_d   = MemReady ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target is computed here so BEQ only has to compare.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = MemReady ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_we    = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc  = 1'b1;
            mem_we  = 1'b1;
            state_d = MemReady ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: reg_we = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = ALUOP_SUB;
            pc_we   = Zero;
         end
         S_JAL: begin
            // Link value OldPC+4 goes through ALUWB; PC takes the target already in ALUOut.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pc_we   = 1'b1;
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         ALUOP_SUB: ALUControl = 3'b001;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] && funct7) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   // Architectural write strobes are masked during reset even mid-instruction.
   assign PCWrite   = pc_we  & ~reset;
   assign IRWrite   = ir_we  & ~reset;
   assign MemWrite  = mem_we & ~reset;
   assign RegWrite  = reg_we & ~reset;
   assign IllegalOp = illegal_q;
   assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction stream; each instruction's expected observable footprint is queued
// by the stimulus and checked per FETCH-to-FETCH window by an independent monitor.
module tb_multicycle_control_fsm;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   logic       clk = 1'b0;
   logic       reset, funct7, Zero, MemReady;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl), .IllegalOp(IllegalOp),
      .State(State)
   );

   typedef struct {
      int          cycles;
      logic [31:0] trace;
      int          n_ir, n_pc, n_reg, n_regmem, n_mw, n_adr, n_fok, n_dok, n_ill;
      logic [1:0]  imm;
      logic [2:0]  alu;
   } win_t;

   win_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic win_t win_zero();
      win_t w;
      w.cycles = 0; w.trace = 32'h0; w.n_ir = 0; w.n_pc = 0; w.n_reg = 0; w.n_regmem = 0;
      w.n_mw = 0; w.n_adr = 0; w.n_fok = 0; w.n_dok = 0; w.n_ill = 0; w.imm = 2'b00; w.alu = 3'b000;
      return w;
   endfunction

   function automatic logic supported(input logic [6:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
   endfunction

   function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
         3'd2:    return 3'd5;
         3'd6:    return 3'd3;
         3'd7:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   // Expected footprint of one instruction from FETCH entry to the next FETCH entry.
   function automatic win_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input logic z, input int fst, input int mst, input logic pill);
      win_t e = win_zero();
      e.cycles = fst + 2;
      e.trace  = 32'h01;
      e.n_ir   = 1;
      e.n_pc   = 1;
      e.n_fok  = fst + 1;
      e.n_dok  = 1;
      e.n_ill  = pill ? 1 : 0;
      case (o)
         LW: begin e.cycles += 3 + mst; e.trace = 32'h01234; e.n_reg = 1; e.n_regmem = 1; e.n_adr = mst + 1; end
         SW: begin e.cycles += 2 + mst; e.trace = 32'h0125; e.n_mw = mst + 1; e.n_adr = mst + 1; e.imm = 2'd1; end
         RT: begin e.cycles += 2; e.trace = 32'h0168; e.n_reg = 1; e.alu = alu_ref(o, f3, f7); end
         IT: begin e.cycles += 2; e.trace = 32'h0178; e.n_reg = 1; e.alu = alu_ref(o, f3, f7); end
         BQ: begin e.cycles += 1; e.trace = 32'h019; e.n_pc += z ? 1 : 0; e.alu = 3'd1; e.imm = 2'd2; end
         JL: begin e.cycles += 2; e.trace = 32'h01A8; e.n_pc += 1; e.n_reg = 1; e.imm = 2'd3; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic cmp_win(input win_t e, input win_t o);
      chk("win_cycles", 32'(o.cycles), 32'(e.cycles));
      chk("win_trace", o.trace, e.trace);
      chk("win_irwrite", 32'(o.n_ir), 32'(e.n_ir));
      chk("win_pcwrite", 32'(o.n_pc), 32'(e.n_pc));
      chk("win_regwrite", 32'(o.n_reg), 32'(e.n_reg));
      chk("win_regwrite_data", 32'(o.n_regmem), 32'(e.n_regmem));
      chk("win_memwrite", 32'(o.n_mw), 32'(e.n_mw));
      chk("win_adrsrc", 32'(o.n_adr), 32'(e.n_adr));
      chk("win_fetch_ctl", 32'(o.n_fok), 32'(e.n_fok));
      chk("win_decode_ctl", 32'(o.n_dok), 32'(e.n_dok));
      chk("win_illegal", 32'(o.n_ill), 32'(e.n_ill));
      chk("win_immsrc", 32'(o.imm), 32'(e.imm));
      chk("win_aluctl", 32'(o.alu), 32'(e.alu));
   endtask

   // Monitor: windows open on every entry into FETCH.
   win_t       cur;
   logic       active = 1'b0;
   logic [3:0] prev_st = 4'd0;

   always @(negedge clk) begin
      if (!mon_en) begin
         active = 1'b0;
      end else begin
         if (State == 4'd0 && (!active || prev_st != 4'd0)) begin
            if (active) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL sb_extra: got an unexpected instruction window, expected none");
               end else begin
                  cmp_win(sb_q.pop_front(), cur);
               end
            end
            cur    = win_zero();
            active = 1'b1;
         end else if (State != prev_st) begin
            cur.trace = {cur.trace[27:0], State};
         end
         cur.cycles++;
         if (IRWrite) cur.n_ir++;
         if (PCWrite) cur.n_pc++;
         if (RegWrite) cur.n_reg++;
         if (RegWrite && ResultSrc == 2'b01) cur.n_regmem++;
         if (MemWrite) cur.n_mw++;
         if (AdrSrc) cur.n_adr++;
         if (IllegalOp) cur.n_ill++;
         if (State == 4'd0 && !AdrSrc && ALUSrcA == 2'b00 && ALUSrcB == 2'b10 &&
             ALUControl == 3'b000 && ResultSrc == 2'b10) cur.n_fok++;
         if (State == 4'd1) begin
            cur.imm = ImmSrc;
            if (ALUSrcA == 2'b01 && ALUSrcB == 2'b01 && ALUControl == 3'b000) cur.n_dok++;
         end
         if (State == 4'd6 || State == 4'd7 || State == 4'd9) cur.alu = ALUControl;
         prev_st = State;
      end
   end

   task automatic cyc(input logic mr, input logic z);
      MemReady = mr;
      Zero     = z;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                            input int fst, input int mst, input logic pill);
      op = o; funct3 = f3; funct7 = f7;
      sb_q.push_back(model(o, f3, f7, z, fst, mst, pill));
      repeat (fst) cyc(1'b0, rb());
      cyc(1'b1, rb());
      cyc(rb(), rb());
      case (o)
         LW: begin cyc(rb(), rb()); repeat (mst) cyc(1'b0, rb()); cyc(1'b1, rb()); cyc(rb(), rb()); end
         SW: begin cyc(rb(), rb()); repeat (mst) cyc(1'b0, rb()); cyc(1'b1, rb()); end
         RT, IT, JL: begin cyc(rb(), rb()); cyc(rb(), rb()); end
         BQ: cyc(rb(), z);
         default: ;
      endcase
   endtask

   logic [6:0] fx_op [7];
   logic       fx_f7 [7];
   logic       fx_z  [7];
   int         fx_m  [7];

   initial begin
      logic [6:0] o;
      logic       pill;
      int         sel, fst, mst;
      fx_op = '{LW, SW, RT, IT, BQ, BQ, 7'h7F};
      fx_f7 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      fx_z  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      fx_m  = '{0, 3, 0, 0, 0, 0, 0};

      reset = 1'b1; MemReady = 1'b1; op = RT; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_pcwrite_forced", 32'(PCWrite), 32'd0);
      chk("rst_irwrite_forced", 32'(IRWrite), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_state", 32'(State), 32'd0);
      chk("rst_illegal", 32'(IllegalOp), 32'd0);
      chk("fetch1_irwrite", 32'(IRWrite), 32'd1);
      chk("fetch1_pcwrite", 32'(PCWrite), 32'd1);
      chk("fetch1_alusrcb", 32'(ALUSrcB), 32'd2);
      @(negedge clk);
      chk("fetch1_next_state", 32'(State), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;

      pill = 1'b0;
      for (int i = 0; i < 67; i++) begin
         if (i < 7) begin
            run_instr(fx_op[i], 3'd0, fx_f7[i], fx_z[i], 0, fx_m[i], pill);
            pill = !supported(fx_op[i]);
         end else begin
            sel = $urandom_range(0, 6);
            case (sel)
               0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = BQ; 5: o = JL;
               default: begin
                  o = 7'($urandom);
                  while (supported(o)) o = 7'($urandom);
               end
            endcase
            fst = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            mst = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_instr(o, 3'($urandom_range(0, 7)), rb(), rb(), fst, mst, pill);
            pill = !supported(o);
         end
      end
      repeat (3) cyc(1'b0, 1'b0);
      mon_en = 1'b0;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      // Reset arriving while a store is waiting on memory.
      op = SW; funct3 = 3'd2; funct7 = 1'b0;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      MemReady = 1'b0;
      chk("mw_enter", 32'(State), 32'd5);
      @(negedge clk);
      chk("mw_held", 32'(MemWrite), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("mw_rst_memwrite", 32'(MemWrite), 32'd0);
      chk("mw_rst_state_before_edge", 32'(State), 32'd5);
      @(posedge clk);
      #1;
      chk("mw_rst_state", 32'(State), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mw_rst_no_illegal", 32'(IllegalOp), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
